serial_frame_detector: RTL and testbench
========================================

Name: serial_frame_detector

Overview:
- Parametrised successor to the lab's single-pattern serial detector.
- Turns a slow push-button-style `in_pulse` into a one-cycle bit-enable `clk_en`, then scans `ser_in` on each enable for a programmable start pattern.
- After a match, forwards the next PAYLOAD_LEN bits to `ser_out` with a valid strobe and a running bit count.
- Sits between the board input conditioning and the display/counter logic in the lab top level.

Parameters:
- PAT_W, 6, pattern width in bits (2..16).
- PATTERN, 6'b110101, start pattern; MSB is the oldest bit received.
- PAYLOAD_LEN, 8, payload bits forwarded per detected frame (1..2^CNT_W-1).
- CNT_W, 4, width of `cnt_out`.
- OVERLAP, 1, 1 = history is retained across frames; 0 = history is flushed on return to search.
- DCNT_W, 8, width of the optional frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_pulse  in  1  asynchronous level input, one bit time per rising edge.
- ser_in  in  1  serial data, sampled only on `clk_en` cycles.
- clk_en  out  1  one-cycle bit-enable strobe derived from `in_pulse`.
- ser_out  out  1  forwarded payload bit.
- ser_out_valid  out  1  one-cycle strobe, high when `ser_out` holds a new payload bit.
- cnt_out  out  CNT_W  payload bits emitted in the current/last frame.
- busy  out  1  high while in PAYLOAD state.
- det_cnt  out  DCNT_W  frames detected (only with FRAME_CNT_EN).

Behaviour:
- Reset (`rst`=0, asynchronous): every flop clears.
  - `clk_en`, `ser_out`, `ser_out_valid`, `cnt_out`, `busy`, `det_cnt` = 0.
  - State = SEARCH; history register and fill count = 0.
  - Reset mid-frame aborts the frame; no partial output is produced after release.
- Enable generation:
  - `in_pulse` passes through a 2-flop synchroniser, then a rising-edge detector.
  - `clk_en` is high for exactly one cycle, on the 3rd rising `clk` edge after `in_pulse` rises (the first edge that samples it high).
  - Holding `in_pulse` high gives one pulse only.
  - If `in_pulse` is high when reset releases, one `clk_en` pulse is generated.
- All serial logic advances only in cycles where `clk_en`=1; otherwise all state holds.
- History register:
  - Every `clk_en`: `hist <= {hist[PAT_W-2:0], ser_in}`, in both states.
  - `fill` increments and saturates at PAT_W.
- SEARCH state:
  - Match when the updated history equals PATTERN and `fill` (including this bit) is at least PAT_W.
  - On match, in the same edge: state goes to PAYLOAD, `cnt_out` goes to 0, `busy` goes to 1, `det_cnt` increments (saturating at all-ones).
  - The matching bit itself is not payload.
- PAYLOAD state, on each `clk_en`:
  - `ser_out` <= `ser_in`; `ser_out_valid` <= 1 for that cycle only; `cnt_out` <= `cnt_out`+1.
  - When `cnt_out` reaches PAYLOAD_LEN, state goes to SEARCH and `busy` goes to 0 on that same edge.
  - The pattern is not checked during PAYLOAD.
- Between strobes: `ser_out` holds its last value, `ser_out_valid` = 0, and `cnt_out` holds (it retains the final count until the next match).
- Latency: `ser_out_valid` rises on the same edge as `clk_en` falls, i.e. one cycle after the enable cycle.
- Return to SEARCH, depending on OVERLAP:
  - OVERLAP=1: history and fill are kept, so payload tail bits can form the next pattern; the earliest match is on the 1st search bit.
  - OVERLAP=0: fill clears to 0, and PAT_W fresh bits are needed before a match.
- Inside SEARCH, overlapping patterns always match; there is no flush after a match in SEARCH, because a match always leaves SEARCH.
- Widths: `cnt_out` compare is CNT_W-bit unsigned. Elaboration fails (`$error` in a generate check) if PAYLOAD_LEN > 2^CNT_W-1 or PAT_W < 2.

Optional Feature:
- Macro: FRAME_CNT_EN.
- Defined: the `det_cnt` port and a DCNT_W saturating counter exist. It increments once per detected frame, saturates at 2^DCNT_W-1, and is cleared only by reset.
- Undefined: the `det_cnt` port and its logic are absent; all other behaviour is identical.

Test Plan:
- Power-on: `rst`=0 for 50 ns, `in_pulse` toggling -> `clk_en`=0 and all outputs 0 until 3 edges after the first post-reset rising edge of `in_pulse`.
- Enable shaping: `in_pulse` held high for 10 cycles -> exactly one `clk_en` pulse, on the 3rd edge; re-rise 4 cycles later -> a second single pulse.
- Defaults, bits 0,0,1,1,0,1,0,1 then 8 payload bits 1,0,0,1,1,1,0,1:
  - `busy` rises on the 8th enable.
  - 8 `ser_out_valid` strobes with `ser_out` = 1,0,0,1,1,1,0,1 and `cnt_out` stepping 1..8.
  - `busy` falls with the 8th strobe; `det_cnt`=1.
- Overlap, PAYLOAD_LEN=6, payload 1,1,0,1,0,1, next search bit 1 (history now 101011 ≠ PATTERN): no match.
  - Instead feed payload 0,1,1,0,1,0 then search bit 1 (history 110101) -> with OVERLAP=1 a match on the first search bit, `busy` re-asserts.
  - Same stimulus with OVERLAP=0 -> no match until 6 fresh bits 110101 arrive.
- Reset mid-frame: assert `rst` after the 3rd payload strobe -> `busy`, `cnt_out`, `det_cnt` immediately 0. After release, the frame remainder does not produce strobes until a new full pattern is seen.
- Non-match: 20 enables of ser_in=0 -> no `busy`, no `ser_out_valid`, `cnt_out` stays at its previous value.

Source files
------------

// File: rtl/serial_frame_detector_if.sv
// Serial detector signal bundle: pulse/data toward the detector, payload stream back out.
// det_cnt is present only when FRAME_CNT_EN is defined.
interface serial_frame_detector_if #(
   parameter int CNT_W  = 4,
   parameter int DCNT_W = 8
);
   logic              in_pulse;
   logic              ser_in;
   logic              clk_en;
   logic              ser_out;
   logic              ser_out_valid;
   logic [CNT_W-1:0]  cnt_out;
   logic              busy;
`ifdef FRAME_CNT_EN
   logic [DCNT_W-1:0] det_cnt;

   modport master (
      input  in_pulse, ser_in,
      output clk_en, ser_out, ser_out_valid, cnt_out, busy, det_cnt
   );
   modport slave (
      output in_pulse, ser_in,
      input  clk_en, ser_out, ser_out_valid, cnt_out, busy, det_cnt
   );
`else
   modport master (
      input  in_pulse, ser_in,
      output clk_en, ser_out, ser_out_valid, cnt_out, busy
   );
   modport slave (
      output in_pulse, ser_in,
      input  clk_en, ser_out, ser_out_valid, cnt_out, busy
   );
`endif

   if (CNT_W < 1 || DCNT_W < 1) begin : g_bad_width
      $error("serial_frame_detector_if: CNT_W and DCNT_W must be positive");
   end
endinterface

// File: rtl/serial_frame_detector.sv
// Pulse-to-enable shaper plus start-pattern scanner forwarding PAYLOAD_LEN bits; clk_en 3 edges after in_pulse rises,
// ser_out_valid one cycle after each enable; no backpressure. Optional det_cnt frame counter under FRAME_CNT_EN.
module serial_frame_detector #(
   parameter int               PAT_W       = 6,
   parameter logic [PAT_W-1:0] PATTERN     = 6'b110101,
   parameter int               PAYLOAD_LEN = 8,
   parameter int               CNT_W       = 4,
   parameter int               OVERLAP     = 1,
   parameter int               DCNT_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   serial_frame_detector_if.master bus
);
   localparam int                FILL_W   = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PAYLOAD_LEN);

   if (PAT_W < 2 || PAT_W > 16 || PAYLOAD_LEN < 1 ||
       PAYLOAD_LEN > (2 ** CNT_W) - 1 || DCNT_W < 1) begin : g_bad_cfg
      $error("serial_frame_detector: illegal PAT_W / PAYLOAD_LEN / CNT_W / DCNT_W");
   end

   typedef enum logic {SEARCH, PAYLOAD} state_t;

   state_t             state, state_nxt;
   logic               sync1, sync2, pulse_d, en_q;
   // Only PAT_W-1 old bits are stored; the newest bit is ser_in itself at match time.
   logic [PAT_W-2:0]   hist_q, hist_nxt;
   logic [PAT_W-1:0]   hist_sh;
   logic [FILL_W-1:0]  fill_q, fill_nxt, fill_inc;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt, cnt_inc;
   logic               sout_q, sout_nxt;
   logic               vld_q, vld_nxt;
   logic               match;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         pulse_d <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         sync1   <= bus.in_pulse;
         sync2   <= sync1;
         pulse_d <= sync2;
         en_q    <= sync2 & ~pulse_d;
      end
   end

   always_comb begin
      state_nxt = state;
      hist_nxt  = hist_q;
      fill_nxt  = fill_q;
      cnt_nxt   = cnt_q;
      sout_nxt  = sout_q;
      vld_nxt   = 1'b0;
      match     = 1'b0;
      hist_sh   = {hist_q, bus.ser_in};
      fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      cnt_inc   = cnt_q + 1'b1;
      if (en_q) begin
         hist_nxt = hist_sh[PAT_W-2:0];
         fill_nxt = fill_inc;
         case (state)
            SEARCH: begin
               if (hist_sh == PATTERN && fill_inc == FILL_MAX) begin
                  match     = 1'b1;
                  state_nxt = PAYLOAD;
                  cnt_nxt   = '0;
               end
            end
            PAYLOAD: begin
               sout_nxt = bus.ser_in;
               vld_nxt  = 1'b1;
               cnt_nxt  = cnt_inc;
               if (cnt_inc == CNT_LAST) begin
                  state_nxt = SEARCH;
                  if (OVERLAP == 0) fill_nxt = '0;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= SEARCH;
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         sout_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         hist_q <= hist_nxt;
         fill_q <= fill_nxt;
         cnt_q  <= cnt_nxt;
         sout_q <= sout_nxt;
         vld_q  <= vld_nxt;
      end
   end

`ifdef FRAME_CNT_EN
   logic [DCNT_W-1:0] det_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         det_q <= '0;
      end else if (match && det_q != '1) begin
         det_q <= det_q + 1'b1;
      end
   end

   assign bus.det_cnt = det_q;
`endif

   assign bus.clk_en        = en_q;
   assign bus.ser_out       = sout_q;
   assign bus.ser_out_valid = vld_q;
   assign bus.cnt_out       = cnt_q;
   assign bus.busy          = (state == PAYLOAD);
endmodule

// File: tb/tb_serial_frame_detector.sv
// Three detector instances (8-bit overlap, 6-bit overlap, 6-bit flush) share one stimulus stream and are
// compared every cycle against a bit-level frame model, plus hand-computed checks of the directed scenarios.
module tb_serial_frame_detector;
   localparam int         CNT_W  = 4;
   localparam int         DCNT_W = 8;
   localparam int         NDUT   = 3;
   localparam logic [5:0] PAT    = 6'b110101;

   logic clk      = 1'b0;
   logic rst      = 1'b0;
   logic in_pulse = 1'b0;
   logic ser_in   = 1'b0;

   always #5 clk = ~clk;

   logic [NDUT-1:0]  en_o, sout_o, vld_o, busy_o;
   logic [CNT_W-1:0] cnt_o [NDUT];
`ifdef FRAME_CNT_EN
   logic [DCNT_W-1:0] det_o [NDUT];
`endif

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      serial_frame_detector_if #(.CNT_W(CNT_W), .DCNT_W(DCNT_W)) sif ();
      assign sif.in_pulse = in_pulse;
      assign sif.ser_in   = ser_in;
      serial_frame_detector #(
         .PAT_W(6), .PATTERN(PAT), .PAYLOAD_LEN(g == 0 ? 8 : 6), .CNT_W(CNT_W),
         .OVERLAP(g == 2 ? 0 : 1), .DCNT_W(DCNT_W)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (sif.master)
      );
      assign en_o[g]   = sif.clk_en;
      assign sout_o[g] = sif.ser_out;
      assign vld_o[g]  = sif.ser_out_valid;
      assign busy_o[g] = sif.busy;
      assign cnt_o[g]  = sif.cnt_out;
`ifdef FRAME_CNT_EN
      assign det_o[g]  = sif.det_cnt;
`endif
   end

   int vectors     = 0;
   int miscompares = 0;
   int strobes0    = 0;
   logic [4:0] log0 [$];

   function automatic int plen(input int d);
      return (d == 0) ? 8 : 6;
   endfunction
   function automatic bit overlap(input int d);
      return (d != 2);
   endfunction

   // Model: pulse samples seen at the last three edges, and per-instance frame progress.
   bit m_en, p1, p2, p3;
   int m_h [NDUT];
   int m_n [NDUT];
   int m_cnt [NDUT];
   int m_det [NDUT];
   bit m_pay [NDUT];
   bit m_vld [NDUT];
   bit m_sout [NDUT];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_en = 0; p1 = 0; p2 = 0; p3 = 0;
         for (int d = 0; d < NDUT; d++) begin
            m_h[d] = 0; m_n[d] = 0; m_cnt[d] = 0; m_det[d] = 0;
            m_pay[d] = 0; m_vld[d] = 0; m_sout[d] = 0;
         end
      end else begin
         bit bit_time;
         bit_time = m_en;
         m_en = p2 & ~p3;
         p3 = p2; p2 = p1; p1 = in_pulse;
         for (int d = 0; d < NDUT; d++) begin
            m_vld[d] = 0;
            if (bit_time) begin
               m_h[d] = ((m_h[d] << 1) | int'(ser_in)) & 63;
               m_n[d] = m_n[d] + 1;
               if (!m_pay[d]) begin
                  if (m_n[d] >= 6 && m_h[d] == int'(PAT)) begin
                     m_pay[d] = 1;
                     m_cnt[d] = 0;
                     if (m_det[d] < 255) m_det[d] = m_det[d] + 1;
                  end
               end else begin
                  m_sout[d] = ser_in;
                  m_vld[d]  = 1;
                  m_cnt[d]  = m_cnt[d] + 1;
                  if (m_cnt[d] == plen(d)) begin
                     m_pay[d] = 0;
                     if (!overlap(d)) m_n[d] = 0;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         bit det_ok;
         det_ok = 1'b1;
`ifdef FRAME_CNT_EN
         det_ok = (det_o[d] === DCNT_W'(m_det[d]));
`endif
         vectors++;
         if (en_o[d] !== m_en || sout_o[d] !== m_sout[d] || vld_o[d] !== m_vld[d] ||
             busy_o[d] !== m_pay[d] || cnt_o[d] !== CNT_W'(m_cnt[d]) || !det_ok) begin
            miscompares++;
            $display("FAIL model dut%0d t=%0t: got en=%b out=%b vld=%b busy=%b cnt=%0d det_ok=%b, want en=%b out=%b vld=%b busy=%b cnt=%0d det=%0d",
                     d, $time, en_o[d], sout_o[d], vld_o[d], busy_o[d], cnt_o[d], det_ok,
                     m_en, m_sout[d], m_vld[d], m_pay[d], m_cnt[d], m_det[d]);
         end
      end
      if (vld_o[0] === 1'b1) begin
         strobes0++;
         log0.push_back({sout_o[0], cnt_o[0]});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input int exp);
      vectors++;
      if (act !== 32'(exp)) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      ser_in   = b;
      in_pulse = 1'b1;
      repeat (3) @(negedge clk);
      in_pulse = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_random(input logic b);
      int h, l;
      h = $urandom_range(1, 5);
      l = $urandom_range(1, 4);
      if (h + l < 4) l = 4 - h;
      @(negedge clk);
      ser_in   = b;
      in_pulse = 1'b1;
      repeat (h) @(negedge clk);
      in_pulse = 1'b0;
      repeat (l) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
         ser_in = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic pulse_window(input int high_cyc, input int low_cyc, output int first, output int count);
      first = -1;
      count = 0;
      @(negedge clk);
      in_pulse = 1'b1;
      for (int i = 1; i <= high_cyc + low_cyc; i++) begin
         @(posedge clk);
         #1;
         if (en_o[0] === 1'b1) begin
            count++;
            if (first < 0) first = i;
         end
         if (i == high_cyc) in_pulse = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, count;
      logic [7:0] pay;
      pay = 8'b10011101;

      for (int i = 0; i < 6; i++) #7 in_pulse = ~in_pulse;
      in_pulse = 1'b0;
      #6;
      check("reset_outputs", {en_o[0], sout_o[0], vld_o[0], busy_o[0], cnt_o[0]}, 0);
      #4 rst = 1'b1;
      repeat (3) @(negedge clk);

      pulse_window(10, 4, first, count);
      check("hold_first_edge", first, 3);
      check("hold_pulse_count", count, 1);
      pulse_window(3, 5, first, count);
      check("rerise_first_edge", first, 3);
      check("rerise_pulse_count", count, 1);

      log0.delete();
      strobes0 = 0;
      send_bits(16'b0011010, 7);
      check("frame_busy_before_match", busy_o[0], 0);
      send_bit(1'b1);
      check("frame_busy_on_match", busy_o[0], 1);
      send_bits(16'(pay), 8);
      check("frame_busy_after", busy_o[0], 0);
      check("frame_strobe_count", log0.size(), 8);
      for (int i = 0; i < log0.size() && i < 8; i++)
         check($sformatf("frame_payload_%0d", i), log0[i], {pay[7-i], 4'(i + 1)});
`ifdef FRAME_CNT_EN
      check("frame_det_cnt", det_o[0], 1);
`endif

      strobes0 = 0;
      repeat (20) send_bit(1'b0);
      check("nomatch_strobes", strobes0, 0);
      check("nomatch_cnt_hold", cnt_o[0], 8);
      check("nomatch_busy", busy_o[0], 0);

      do_reset();
      send_bits(16'(PAT), 6);
      send_bits(16'b110101, 6);
      send_bit(1'b1);
      check("ovl_tail_101011_nomatch", busy_o[1], 0);

      do_reset();
      send_bits(16'(PAT), 6);
      send_bits(16'b011010, 6);
      send_bit(1'b1);
      check("ovl1_first_bit_match", busy_o[1], 1);
      check("ovl0_first_bit_nomatch", busy_o[2], 0);
      send_bits(16'b1010, 4);
      check("ovl0_five_fresh_nomatch", busy_o[2], 0);
      send_bit(1'b1);
      check("ovl0_six_fresh_match", busy_o[2], 1);

      do_reset();
      send_bits(16'(PAT), 6);
      strobes0 = 0;
      send_bits(16'b101, 3);
      check("midrst_strobes_before", strobes0, 3);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_outputs_cleared", {busy_o[0], cnt_o[0], vld_o[0]}, 0);
`ifdef FRAME_CNT_EN
      check("midrst_det_cleared", det_o[0], 0);
`endif
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      strobes0 = 0;
      send_bits(16'b00000, 5);
      check("midrst_no_remainder", strobes0, 0);
      check("midrst_busy", busy_o[0], 0);

      do_reset();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            for (int k = 5; k >= 0; k--) send_random(PAT[k]);
         end else begin
            send_random(1'($urandom));
         end
      end
      repeat (8) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
